// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops bytes from the TX FIFO and serialises them as 8N1 at baud_div_i clocks per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_engine #(
    parameter int DIV_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_en_i,
    input  logic                 tx_fifo_empty_i,
    input  logic [7:0]           tx_data_i,
    input  logic [DIV_WIDTH-1:0] baud_div_i,
    output logic                 tx_fifo_rd_en_o,
    output logic                 txd_o,
    output logic                 tx_busy_o,
    output logic                 tx_done_o
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } state_t;
`endif

    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

    state_t               r_state;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_div_q;
    logic [2:0]           r_idx;
    logic [7:0]           r_shift;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic w_start_ok;
    logic w_bit_end;
    logic w_stop_last_next;
    logic w_div_is_one;

    assign w_start_ok       = tx_en_i && !tx_fifo_empty_i && (baud_div_i != '0);
    assign w_bit_end        = (r_cnt == r_div_q - ONE);
    // True when the cycle after this one is the final cycle of the current bit.
    assign w_stop_last_next = (r_cnt + ONE == r_div_q - ONE);
    assign w_div_is_one     = (r_div_q == ONE);

    // NOTE: every register here is state, so all updates use <= to take effect together at the edge;
    // a blocking = would let later statements see the new value within the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_div_q         <= '0;
            r_idx           <= '0;
            r_shift         <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity        <= 1'b0;
`endif
            txd_o           <= 1'b1;
            tx_fifo_rd_en_o <= 1'b0;
            tx_busy_o       <= 1'b0;
            tx_done_o       <= 1'b0;
        end else begin
            tx_fifo_rd_en_o <= 1'b0;
            tx_done_o       <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    txd_o <= 1'b1;
                    r_cnt <= '0;
                    r_idx <= '0;
                    if (w_start_ok) begin
                        r_state         <= ST_POP;
                        tx_fifo_rd_en_o <= 1'b1;
                        tx_busy_o       <= 1'b1;
                    end else begin
                        tx_busy_o <= 1'b0;
                    end
                end

                ST_POP: begin
                    r_state <= ST_LOAD;
                end

                // The registered-read FIFO presents the popped byte during this cycle.
                ST_LOAD: begin
                    r_shift <= tx_data_i;
                    r_div_q <= baud_div_i;
`ifdef UART_TX_PARITY_EN
                    r_parity <= ^tx_data_i;
`endif
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_state <= ST_START;
                    txd_o   <= 1'b0;
                end

                ST_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= ST_DATA;
                        txd_o   <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                end

                ST_DATA: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_idx == 3'd7) begin
                            r_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            r_state <= ST_PARITY;
                            txd_o   <= r_parity;
`else
                            r_state   <= ST_STOP;
                            txd_o     <= 1'b1;
                            tx_done_o <= w_div_is_one;
`endif
                        end else begin
                            r_idx <= r_idx + 3'd1;
                            txd_o <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                end

`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_state   <= ST_STOP;
                        txd_o     <= 1'b1;
                        tx_done_o <= w_div_is_one;
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                end
`endif

                // Done is registered one cycle early so it lines up with the last stop cycle.
                ST_STOP: begin
                    txd_o <= 1'b1;
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_start_ok) begin
                            r_state         <= ST_POP;
                            tx_fifo_rd_en_o <= 1'b1;
                            tx_busy_o       <= 1'b1;
                        end else begin
                            r_state   <= ST_IDLE;
                            tx_busy_o <= 1'b0;
                        end
                    end else begin
                        r_cnt     <= r_cnt + ONE;
                        tx_done_o <= w_stop_last_next;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    txd_o     <= 1'b1;
                    tx_busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: a queue-based FIFO model plus a frame model built from the 8N1(+P) rules.
// Build with UART_TX_PARITY_EN defined to exercise the parity variant.
module tb_uart_tx_engine;

    localparam int DIV_WIDTH = 32;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic                 clk;
    logic                 rst;
    logic                 tx_en_i;
    logic                 tx_fifo_empty_i;
    logic [7:0]           tx_data_i;
    logic [DIV_WIDTH-1:0] baud_div_i;
    logic                 tx_fifo_rd_en_o;
    logic                 txd_o;
    logic                 tx_busy_o;
    logic                 tx_done_o;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         rd_pulses = 0;
    logic [7:0] fifo_q[$];
    bit         pop_pending = 0;

    uart_tx_engine #(.DIV_WIDTH(DIV_WIDTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .tx_en_i         (tx_en_i),
        .tx_fifo_empty_i (tx_fifo_empty_i),
        .tx_data_i       (tx_data_i),
        .baud_div_i      (baud_div_i),
        .tx_fifo_rd_en_o (tx_fifo_rd_en_o),
        .txd_o           (txd_o),
        .tx_busy_o       (tx_busy_o),
        .tx_done_o       (tx_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read FIFO: read data is valid only in the cycle after the pop strobe, garbage otherwise.
    always @(posedge clk) begin
        #1;
        if (pop_pending && fifo_q.size() > 0) tx_data_i = fifo_q.pop_front();
        else                                  tx_data_i = 8'($urandom);
        pop_pending = 0;
        if (tx_fifo_rd_en_o === 1'b1) begin
            rd_pulses++;
            pop_pending = 1;
        end
        tx_fifo_empty_i = (fifo_q.size() == 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        tx_fifo_empty_i = 1'b0;
    endtask

    // Expected line levels, LSB = first bit on the wire: start 0, data LSB first, [even parity], stop 1.
    function automatic logic [10:0] frame_word(input logic [7:0] b);
        logic [10:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        w[9] = ^b;
`endif
        w[NBITS-1] = 1'b1;
        return w;
    endfunction

    task automatic wait_start(input string tag, output int marks, output bit found);
        marks = 0;
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (txd_o === 1'b0) found = 1;
            else                marks++;
        end
        if (!found) check({tag, "_start_timeout"}, 1, 0);
    endtask

    // Called on the negedge of the first start-bit cycle; returns on the negedge of the last stop cycle.
    task automatic read_frame(input logic [7:0] b, input int div, input string tag, output logic [10:0] obs);
        int glitch, done_cnt, done_at, busy_low;
        obs = '0;
        glitch = 0; done_cnt = 0; done_at = -1; busy_low = 0;
        for (int k = 0; k < NBITS; k++) begin
            for (int c = 0; c < div; c++) begin
                if (!(k == 0 && c == 0)) @(negedge clk);
                if (c == 0)              obs[k] = txd_o;
                else if (txd_o !== obs[k]) glitch++;
                if (tx_done_o === 1'b1) begin
                    done_cnt++;
                    done_at = k * div + c;
                end
                if (tx_busy_o !== 1'b1) busy_low++;
            end
        end
        check({tag, "_bits"},     32'(obs),      32'(frame_word(b)));
        check({tag, "_bitlen"},   32'(glitch),   0);
        check({tag, "_done_cnt"}, 32'(done_cnt), 1);
        check({tag, "_done_at"},  32'(done_at),  32'(NBITS * div - 1));
        check({tag, "_busy"},     32'(busy_low), 0);
    endtask

    task automatic expect_frame(input logic [7:0] b, input int div, input string tag, input bit chk_gap,
                                output logic [10:0] obs);
        int marks;
        bit found;
        obs = '0;
        wait_start(tag, marks, found);
        if (chk_gap) check({tag, "_gap"}, 32'(marks), 2);
        if (found) read_frame(b, div, tag, obs);
    endtask

    task automatic expect_idle_after(input string tag);
        @(negedge clk);
        check({tag, "_busy_end"}, 32'(tx_busy_o), 0);
        check({tag, "_txd_end"},  32'(txd_o),     1);
    endtask

    initial begin
        logic [10:0] obs;
        logic [7:0]  bytes[$];
        int          base, low_cnt, busy_cnt, marks, div, nb;
        bit          found;

        rst = 1'b1;
        tx_en_i = 1'b0;
        tx_fifo_empty_i = 1'b1;
        tx_data_i = '0;
        baud_div_i = '0;
        repeat (3) @(negedge clk);
        check("rst_txd",  32'(txd_o),           1);
        check("rst_busy", 32'(tx_busy_o),       0);
        check("rst_rd",   32'(tx_fifo_rd_en_o), 0);
        check("rst_done", 32'(tx_done_o),       0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte 0xA5 at div=4.
        base = rd_pulses;
        baud_div_i = 4;
        tx_en_i = 1'b1;
        push(8'hA5);
        expect_frame(8'hA5, 4, "single", 0, obs);
        expect_idle_after("single");
        check("single_rd", 32'(rd_pulses - base), 1);
`ifdef UART_TX_PARITY_EN
        check("par_a5", 32'(obs[9]), 0);
        push(8'h07);
        expect_frame(8'h07, 4, "par07", 0, obs);
        check("par_07", 32'(obs[9]), 1);
        expect_idle_after("par07");
`endif

        // Back-to-back 0x55, 0x0F at div=2.
        base = rd_pulses;
        baud_div_i = 2;
        push(8'h55);
        push(8'h0F);
        expect_frame(8'h55, 2, "b2b0", 0, obs);
        expect_frame(8'h0F, 2, "b2b1", 1, obs);
        expect_idle_after("b2b");
        check("b2b_rd", 32'(rd_pulses - base), 2);

        // Zero divisor blocks the pop entirely.
        base = rd_pulses;
        baud_div_i = 0;
        push(8'h3C);
        low_cnt = 0;
        busy_cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (txd_o !== 1'b1)     low_cnt++;
            if (tx_busy_o !== 1'b0) busy_cnt++;
        end
        check("div0_txd",  32'(low_cnt),            0);
        check("div0_busy", 32'(busy_cnt),           0);
        check("div0_rd",   32'(rd_pulses - base),   0);
        check("div0_fifo", 32'(fifo_q.size()),      1);
        baud_div_i = 3;
        expect_frame(8'h3C, 3, "div0_rel", 0, obs);
        expect_idle_after("div0_rel");

        // Enable dropped mid-frame: frame completes, nothing else is popped.
        base = rd_pulses;
        push(8'hE1);
        push(8'h2D);
        push(8'h99);
        wait_start("en_drop", marks, found);
        if (found) begin
            fork
                read_frame(8'hE1, 3, "en_drop", obs);
                begin
                    repeat (10) @(negedge clk);
                    tx_en_i = 1'b0;
                end
            join
        end
        expect_idle_after("en_drop");
        repeat (30) @(negedge clk);
        check("en_drop_rd",   32'(rd_pulses - base), 1);
        check("en_drop_fifo", 32'(fifo_q.size()),    2);
        check("en_drop_idle", 32'(tx_busy_o),        0);
        tx_en_i = 1'b1;
        expect_frame(8'h2D, 3, "en_re0", 0, obs);
        expect_frame(8'h99, 3, "en_re1", 1, obs);
        expect_idle_after("en_re");

        // Divisor change mid-frame applies from the next frame.
        baud_div_i = 4;
        push(8'h96);
        push(8'h3A);
        wait_start("divchg0", marks, found);
        if (found) begin
            fork
                read_frame(8'h96, 4, "divchg0", obs);
                begin
                    repeat (12) @(negedge clk);
                    baud_div_i = 8;
                end
            join
        end
        expect_frame(8'h3A, 8, "divchg1", 1, obs);
        expect_idle_after("divchg");

        // Reset during DATA bit 3 (cycles 16..19 of the frame at div=4).
        baud_div_i = 4;
        push(8'hC3);
        wait_start("rstmid", marks, found);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid_txd",  32'(txd_o),           1);
        check("rstmid_busy", 32'(tx_busy_o),       0);
        check("rstmid_rd",   32'(tx_fifo_rd_en_o), 0);
        @(negedge clk);
        rst = 1'b0;
        base = rd_pulses;
        low_cnt = 0;
        busy_cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (txd_o !== 1'b1)     low_cnt++;
            if (tx_busy_o !== 1'b0) busy_cnt++;
        end
        check("rstmid_idle_txd",  32'(low_cnt),          0);
        check("rstmid_idle_busy", 32'(busy_cnt),         0);
        check("rstmid_idle_rd",   32'(rd_pulses - base), 0);

        // Randomised bursts over divisors 1..6.
        for (int burst = 0; burst < 10; burst++) begin
            div = $urandom_range(1, 6);
            nb  = $urandom_range(1, 3);
            base = rd_pulses;
            baud_div_i = div;
            bytes.delete();
            for (int i = 0; i < nb; i++) bytes.push_back(8'($urandom));
            foreach (bytes[i]) push(bytes[i]);
            foreach (bytes[i]) expect_frame(bytes[i], div, $sformatf("rnd%0d_%0d", burst, i), i > 0, obs);
            expect_idle_after($sformatf("rnd%0d", burst));
            check($sformatf("rnd%0d_rd", burst), 32'(rd_pulses - base), 32'(nb));
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Serial transmit engine: consumer end of the UART TX FIFO in the UART register block.
- Pops bytes from the 8-deep TX FIFO whenever transmit is enabled and the FIFO is non-empty, then serialises each byte onto txd_o as 8N1.
- Bit period is set by the baud-rate divisor register.
- Sits between the register block outputs (tx enable, FIFO data/empty, divisor) and the chip TX pin.

Parameters:
- DIV_WIDTH, 32, width of the baud divisor input and the internal bit-period counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- tx_en_i  input  1  transmit enable (Tx_Ctrl bit 0).
- tx_fifo_empty_i  input  1  TX FIFO empty flag.
- tx_data_i  input  8  TX FIFO read data; valid the cycle after a tx_fifo_rd_en_o pulse (registered-read FIFO).
- baud_div_i  input  DIV_WIDTH  bit period in clk cycles.
- tx_fifo_rd_en_o  output  1  one-cycle FIFO pop strobe.
- txd_o  output  1  serial line; idle/mark = 1.
- tx_busy_o  output  1  high in every state except IDLE.
- tx_done_o  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (asynchronous, immediate):
  - State = IDLE.
  - txd_o = 1, tx_fifo_rd_en_o = 0, tx_busy_o = 0, tx_done_o = 0.
  - Bit counter, bit index and shift register = 0.
  - Reset mid-frame aborts the frame: line returns to 1 at once, and the popped byte is lost.
- All outputs are registered / Moore.
- States: IDLE, POP, LOAD, START, DATA, [PARITY], STOP.
- IDLE:
  - txd_o = 1.
  - Leave to POP when tx_en_i=1 && tx_fifo_empty_i=0 && baud_div_i!=0.
  - baud_div_i==0 keeps the engine in IDLE, with no pop.
- POP:
  - tx_fifo_rd_en_o = 1 for exactly this one cycle; txd_o = 1.
  - Always goes to LOAD next.
- LOAD:
  - Capture tx_data_i into the shift register.
  - Latch baud_div_i into div_q; divisor changes take effect only at the next LOAD.
  - txd_o = 1. Always goes to START next.
- START:
  - txd_o = 0 for div_q cycles.
  - Bit counter runs 0..div_q-1; on div_q-1 it wraps to 0 and the state advances.
- DATA:
  - 8 bits, LSB first, each held div_q cycles; shift right at each bit end.
  - Bit index 0..7; after bit 7, go to PARITY (if compiled in) or STOP.
- STOP:
  - txd_o = 1 for div_q cycles.
  - tx_done_o = 1 on the final cycle of STOP.
  - Next state: POP if tx_en_i=1 && tx_fifo_empty_i=0 && baud_div_i!=0 (sampled in that final cycle); otherwise IDLE.
- Frame length: (10 [+1 parity]) * div_q cycles.
  - Back-to-back frames are separated by exactly 2 extra mark cycles (POP, LOAD).
- tx_en_i deasserted mid-frame: the current frame completes; no further pop.
- FIFO empty is only sampled for the pop decision; empty going high mid-frame has no effect.
- div_q = 1: one clk per bit; the counter never exceeds 0.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - txd_o = even parity (XOR of the 8 data bits) for div_q cycles.
  - Frame length = 11*div_q.
- Undefined:
  - No PARITY state and no parity logic; the 8N1 frame is 10*div_q.

Test Plan:
- Single byte: reset, div=4, tx_en=1, FIFO holds 0xA5.
  - Response: one rd_en pulse.
  - Then, from the first START cycle T0: txd=0 for T0..T0+3, then bits 1,0,1,0,0,1,0,1 each 4 cycles, stop=1 for T0+36..T0+39.
  - tx_done at T0+39, busy low at T0+40.
- Back-to-back: FIFO holds 0x55, 0x0F, div=2.
  - Two frames of 20 cycles each.
  - Exactly 2 mark cycles between the first frame's stop end and the second START.
  - Exactly 2 rd_en pulses.
- Enable/divisor gating:
  - div=0 with a non-empty FIFO -> no rd_en, txd stays 1 for 100 cycles.
  - tx_en dropped mid-frame -> that frame completes (10*div cycles), then IDLE; remaining FIFO data is untouched.
- Divisor change: div changed from 4 to 8 during a frame.
  - The current frame stays at 4 cycles per bit.
  - The next frame runs at 8 cycles per bit.
- Reset mid-frame: rst asserted during DATA bit 3.
  - txd_o=1, busy=0, rd_en=0 in the same cycle.
  - After release with an empty FIFO, the engine stays IDLE.
- Parity (UART_TX_PARITY_EN defined):
  - 0xA5 at div=4 -> parity bit 0, 44-cycle frame.
  - 0x07 -> parity bit 1.
